seq_divider: RTL

//   Multi-cycle unsigned restoring divider; the inverse of the registered multiplier path.

---
 rtl/seq_divider_pkg.sv | 19 +
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and counter sizing.
package seq_divider_pkg;

  localparam int DIV_N = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_FIN  = 2'd2;

  // Step counter must count 0..N-1 and still compare against N-1 without wrap.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CW = cnt_width(DIV_N);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift {R,Q} left by one, then subtract D from R if it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   r_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] d,
  output logic [N:0]   r_out,
  output logic [N-1:0] q_out
);

  logic [N+1:0] r_shift;
  logic [N+1:0] d_ext;
  logic         fits;

  // Shift the partial remainder, compare against the divisor and restore or subtract.
  always_comb begin
    r_shift = {r_in, q_in[N-1]};
    d_ext   = {2'b00, d};
    fits    = (r_shift >= d_ext);
    r_out   = fits ? (N+1)'(r_shift - d_ext) : r_shift[N:0];
    q_out   = {q_in[N-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend by N-bit divisor with start/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           overflow,
  output logic           div_zero
);

  localparam int CNT_W = cnt_width(N);

  state_t           state;
  state_t           state_next;
  logic [N:0]       r_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     d_reg;
  logic [CNT_W-1:0] cnt;
  logic             zero_byp;
  logic             ovf_byp;
  logic [N:0]       r_step;
  logic [N-1:0]     q_step;
  logic [N-1:0]     hi;
  logic             is_zero;
  logic             is_ovf;
  logic             last_step;

  assign hi        = dividend[2*N-1:N];
  assign is_zero   = (divisor == '0);
  assign is_ovf    = !is_zero && (hi >= divisor);
  assign last_step = (cnt == CNT_W'(N-1));

  div_step #(.N(N)) u_step (
    .r_in  (r_reg),
    .q_in  (q_reg),
    .d     (d_reg),
    .r_out (r_step),
    .q_out (q_step)
  );

  // State register with synchronous active-low reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: zero divisor or oversized quotient skips straight to FIN.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (is_zero || is_ovf) ? S_FIN : S_RUN;
      S_RUN:  if (last_step) state_next = S_FIN;
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Busy covers every cycle the engine is not ready to accept a new request.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath: capture operands, iterate the step, and publish results/flags in FIN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      zero_byp  <= 1'b0;
      ovf_byp   <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            d_reg    <= divisor;
            r_reg    <= {1'b0, hi};
            q_reg    <= dividend[N-1:0];
            cnt      <= '0;
            zero_byp <= is_zero;
            ovf_byp  <= is_ovf;
            overflow <= 1'b0;
            div_zero <= 1'b0;
          end
        end
        S_RUN: begin
          r_reg <= r_step;
          q_reg <= q_step;
          cnt   <= cnt + CNT_W'(1);
        end
        S_FIN: begin
          done      <= 1'b1;
          quotient  <= (zero_byp || ovf_byp) ? '1 : q_reg;
          remainder <= r_reg[N-1:0];
          div_zero  <= zero_byp;
          overflow  <= ovf_byp;
        end
        default: ;
      endcase
    end
  end

endmodule
